// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: parametrised VGA timing with one monochrome sprite overlay.
// Sprite rows are fetched one line ahead from a synchronous ROM into a row buffer.
module vga_sprite_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int SPR_W    = 64,
  parameter int SPR_H    = 32,
  parameter int AW       = $clog2(SPR_H)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [10:0]      spr_x_i,
  input  logic [10:0]      spr_y_i,
  input  logic             spr_en_i,
  input  logic [11:0]      fg_color_i,
  input  logic [11:0]      bg_color_i,
  input  logic [SPR_W-1:0] spr_data_i,
  output logic [AW-1:0]    spr_addr_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [3:0]       red_o,
  output logic [3:0]       green_o,
  output logic [3:0]       blue_o,
  output logic             de_o,
  output logic             frame_start_o
);
  localparam int H_T = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_T = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW  = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]    DMAX = DW'(CLK_DIV - 1);
  localparam logic [11:0]      HA   = 12'(H_ACTIVE);
  localparam logic [11:0]      HCAP = 12'(H_ACTIVE + 2);
  localparam logic [11:0]      HT1  = 12'(H_T - 1);
  localparam logic [11:0]      HS0  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0]      HS1  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0]      VA   = 12'(V_ACTIVE);
  localparam logic [11:0]      VT1  = 12'(V_T - 1);
  localparam logic [11:0]      VS0  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0]      VS1  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0]      SW   = 12'(SPR_W);
  localparam logic [11:0]      SH   = 12'(SPR_H);
  localparam logic [SPR_W-1:0] MSB  = SPR_W'(1) << (SPR_W - 1);

  logic [DW-1:0]    div_q, div_d;
  logic [11:0]      h_q, h_d, v_q, v_d, rgb_q, rgb_d;
  logic [10:0]      xl_q, xl_d, yl_q, yl_d;
  logic             enl_q, enl_d, hit_q, hit_d, valid_q, valid_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [SPR_W-1:0] buf_q, buf_d;

  logic        pix_ce, h_end, v_end, latch, pf, cap, vis, in_spr, spr_bit, hit;
  logic [11:0] nv, xl12, yl12, hx;

  always_comb begin
    pix_ce  = div_q == DMAX;
    h_end   = h_q == HT1;
    v_end   = v_q == VT1;
    div_d   = pix_ce ? '0 : div_q + 1'b1;
    h_d     = pix_ce ? (h_end ? 12'd0 : h_q + 12'd1) : h_q;
    v_d     = pix_ce && h_end ? (v_end ? 12'd0 : v_q + 12'd1) : v_q;
    // shadow registers only move at the end of the last line, so a frame never tears
    latch   = pix_ce && h_q == HA && v_end;
    xl_d    = latch ? spr_x_i : xl_q;
    yl_d    = latch ? spr_y_i : yl_q;
    enl_d   = latch ? spr_en_i : enl_q;
    nv      = v_end ? 12'd0 : v_q + 12'd1;
    yl12    = {1'b0, yl_d};
    hit     = enl_d && nv >= yl12 && nv < yl12 + SH;
    pf      = pix_ce && h_q == HA;
    hit_d   = pf ? hit : hit_q;
    addr_d  = pf && hit ? AW'(nv - yl12) : addr_q;
    cap     = pix_ce && h_q == HCAP;
    buf_d   = cap ? spr_data_i : buf_q;
    valid_d = cap ? hit_q : valid_q;
    xl12    = {1'b0, xl_q};
    hx      = h_q - xl12;
    in_spr  = valid_q && h_q >= xl12 && h_q < xl12 + SW;
    spr_bit = |(buf_q & (MSB >> hx));
    vis     = h_q < HA && v_q < VA;
    rgb_d   = pix_ce ? (vis ? (in_spr && spr_bit ? fg_color_i : bg_color_i) : 12'h0) : rgb_q;
    de_d    = pix_ce ? vis : de_q;
    hs_d    = pix_ce ? (h_q >= HS0 && h_q < HS1 ? HS_POL : ~HS_POL) : hs_q;
    vs_d    = pix_ce ? (v_q >= VS0 && v_q < VS1 ? VS_POL : ~VS_POL) : vs_q;
    fs_d    = pix_ce && h_q == 12'd0 && v_q == 12'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      xl_q    <= '0;
      yl_q    <= '0;
      enl_q   <= 1'b0;
      hit_q   <= 1'b0;
      valid_q <= 1'b0;
      buf_q   <= '0;
      addr_q  <= '0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      xl_q    <= xl_d;
      yl_q    <= yl_d;
      enl_q   <= enl_d;
      hit_q   <= hit_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end

  assign spr_addr_o    = addr_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign red_o         = rgb_q[11:8];
  assign green_o       = rgb_q[7:4];
  assign blue_o        = rgb_q[3:0];
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb_vga_sprite_engine: small-timing bench; per-pixel scoreboard plus a table of sprite setups.
module tb_vga_sprite_engine;
  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2;
  localparam int CD = 2, SW = 8, SH = 4;
  localparam int HT = HA + HFP + HSY + HBP, VT = VA + VFP + VSY + VBP;
  localparam logic [11:0] FG = 12'hF0A, BG = 12'h135;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic [10:0] spr_x = '0, spr_y = '0;
  logic spr_en = 1'b0;
  logic [SW-1:0] spr_data = '0;
  logic [1:0] spr_addr;
  logic hsync, vsync, de, fs;
  logic [3:0] red, green, blue;

  always #5 clk = ~clk;

  vga_sprite_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(CD), .SPR_W(SW), .SPR_H(SH), .AW(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .spr_x_i(spr_x), .spr_y_i(spr_y), .spr_en_i(spr_en),
    .fg_color_i(FG), .bg_color_i(BG), .spr_data_i(spr_data), .spr_addr_o(spr_addr),
    .hsync_o(hsync), .vsync_o(vsync), .red_o(red), .green_o(green), .blue_o(blue),
    .de_o(de), .frame_start_o(fs)
  );

  function automatic logic [SW-1:0] rom(input logic [1:0] r);
    return 8'h81 ^ {6'b0, r};
  endfunction

  always @(posedge clk) spr_data <= rom(spr_addr);

  typedef struct { logic [17:0] e; int t; } sb_t;
  sb_t q[$];
  sb_t ms, cs;
  int n_vec = 0, n_mis = 0, cur_cnt = 0, last_cnt = 0;
  int k = 0, t, h, v, nv, mx = 0, my = 0;
  logic men = 1'b0, fgp, vis;
  logic [1:0] maddr = '0;
  logic [SW-1:0] row;
  logic [17:0] got;

  // reference model: derives (h, v) from the tick count and sprite pixels straight from the ROM
  initial forever begin
    @(posedge clk or negedge rst_ni);
    if (!rst_ni) begin
      k = 0; q.delete(); mx = 0; my = 0; men = 1'b0; maddr = '0;
    end else begin
      k++;
      if (k % CD == 0) begin
        t = k / CD - 1;
        h = t % HT;
        v = (t / HT) % VT;
        fgp = 1'b0;
        if (men && v >= my && v < my + SH && h >= mx && h < mx + SW) begin
          row = rom(2'(v - my));
          fgp = row[SW-1-(h-mx)];
        end
        vis = h < HA && v < VA;
        if (h == HA && v == VT - 1) begin mx = spr_x; my = spr_y; men = spr_en; end
        if (h == HA) begin
          nv = (v == VT - 1) ? 0 : v + 1;
          if (men && nv >= my && nv < my + SH) maddr = 2'(nv - my);
        end
        ms.t = t;
        ms.e = {!(h >= HA + HFP && h < HA + HFP + HSY), !(v >= VA + VFP && v < VA + VFP + VSY),
                vis, vis ? (fgp ? FG : BG) : 12'h0, maddr, (h == 0 && v == 0)};
        q.push_back(ms);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    got = {hsync, vsync, de, red, green, blue, spr_addr, fs};
    n_vec++;
    if (q.size() > 0) begin
      cs = q.pop_front();
      if (got !== cs.e) begin
        n_mis++;
        $display("FAIL pixel t=%0d h=%0d v=%0d got=%h exp=%h", cs.t, cs.t % HT, (cs.t / HT) % VT, got, cs.e);
      end
      if (cs.e[0]) begin last_cnt = cur_cnt; cur_cnt = 0; end
      if (de && {red, green, blue} == FG) cur_cnt++;
    end else if (fs !== 1'b0) begin
      n_mis++;
      $display("FAIL fs_idle got=%b exp=0", fs);
    end
  end

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_vec++;
    if (g !== e) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, e);
    end
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fs) return;
    end
    n_mis++;
    $display("FAIL wait_fs timeout");
  endtask

  typedef struct { logic [10:0] x, y; logic en; int cnt; } vec_t;
  vec_t tbl[7];
  int n;

  initial begin
    tbl[0] = '{11'd2,  11'd3,  1'b1, 8};
    tbl[1] = '{11'd2,  11'd3,  1'b0, 0};
    tbl[2] = '{11'd12, 11'd0,  1'b1, 4};
    tbl[3] = '{11'd0,  11'd10, 1'b1, 3};
    tbl[4] = '{11'd16, 11'd2,  1'b1, 0};
    tbl[5] = '{11'd3,  11'd20, 1'b1, 0};
    tbl[6] = '{11'd0,  11'd0,  1'b1, 8};
    repeat (3) @(negedge clk);
    chk("reset_state", {14'b0, hsync, vsync, de, red, green, blue, spr_addr, fs}, 32'h30000);
    rst_ni = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fs && n < 10);
    chk("first_tick", n, CD);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fs && n < 2000);
    chk("frame_period", n, HT * VT * CD);
    for (int i = 0; i < 7; i++) begin
      spr_x = tbl[i].x; spr_y = tbl[i].y; spr_en = tbl[i].en;
      repeat (3) wait_fs();
      @(posedge clk);
      chk($sformatf("fg_count[%0d]", i), last_cnt, tbl[i].cnt);
    end
    spr_x = 11'd2; spr_y = 11'd3; spr_en = 1'b1;
    repeat (2) wait_fs();
    repeat (300) @(negedge clk);
    spr_x = 11'd6;
    wait_fs();
    @(posedge clk);
    chk("midframe_hold", last_cnt, 8);
    wait_fs();
    @(posedge clk);
    chk("new_x", last_cnt, 8);
    repeat (400) @(posedge clk);
    #1 rst_ni = 1'b0;
    #1 chk("async_reset", {14'b0, hsync, vsync, de, red, green, blue, spr_addr, fs}, 32'h30000);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) wait_fs();
    @(posedge clk);
    chk("post_rst_frame0", last_cnt, 0);
    wait_fs();
    @(posedge clk);
    chk("post_rst_frame1", last_cnt, 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
